// File: rtl/pwm_reg_bank.sv
// Register bank for NUM_CH PWM channels: CTRL/STATUS, W1C IRQ status, double-buffered PERIOD/DUTY.
// Latency: writes visible after the write edge; read data and rvalid one cycle after ren.
// Backpressure: none; the bus accepts one access per cycle, and illegal accesses pulse bus_err.
// Ports: clk/reset_n; addr/wdata/wen/ren bus in; rdata/rvalid/bus_err bus out;
//        ctrl, status (status_in delayed), ch_event/ch_reload per channel in,
//        period_o/duty_o packed active values (channel k at [k*DATA_W +: DATA_W]), irq.
module pwm_reg_bank #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     wen,
  input  logic                     ren,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic                     bus_err,
  output logic [DATA_W-1:0]        ctrl,
  input  logic [DATA_W-1:0]        status_in,
  output logic [DATA_W-1:0]        status,
  input  logic [NUM_CH-1:0]        ch_event,
  input  logic [NUM_CH-1:0]        ch_reload,
  output logic [NUM_CH*DATA_W-1:0] period_o,
  output logic [NUM_CH*DATA_W-1:0] duty_o,
  output logic                     irq
);

  // FORCE_UPD (bit 1) is an action, never stored in CTRL.
  localparam logic [DATA_W-1:0] FORCE_MASK = DATA_W'(2);

  logic [31:0]       a32;
  logic              sel_ctrl, sel_stat, sel_istat, sel_ien, sel_pend;
  logic [NUM_CH-1:0] sel_per, sel_dut;
  logic              hit, rd_ok, wr_ok, wr_en, force_upd;
  logic [DATA_W-1:0] rd_val;

  logic [DATA_W-1:0] per_sh   [NUM_CH];
  logic [DATA_W-1:0] dut_sh   [NUM_CH];
  logic [DATA_W-1:0] per_act  [NUM_CH];
  logic [DATA_W-1:0] dut_act  [NUM_CH];
  logic [DATA_W-1:0] per_sh_d [NUM_CH];
  logic [DATA_W-1:0] dut_sh_d [NUM_CH];
  logic [NUM_CH-1:0] pend, ch_wr, reload;
  logic [NUM_CH-1:0] irq_stat, irq_en, irq_stat_d, irq_en_d;
  logic [DATA_W-1:0] ctrl_q;

  assign a32 = 32'(addr);

  // Address decode; exact word compares reject any misaligned address.
  always_comb begin
    sel_ctrl  = (a32 == 32'h00);
    sel_stat  = (a32 == 32'h04);
    sel_istat = (a32 == 32'h08);
    sel_ien   = (a32 == 32'h0C);
    sel_pend  = (a32 == 32'h10);
    for (int k = 0; k < NUM_CH; k++) begin
      sel_per[k] = (a32 == 32'(32'h20 + 8 * k));
      sel_dut[k] = (a32 == 32'(32'h24 + 8 * k));
    end
    hit   = sel_ctrl | sel_stat | sel_istat | sel_ien | sel_pend | (|sel_per) | (|sel_dut);
    rd_ok = hit;
    wr_ok = hit & ~sel_stat & ~sel_pend;
    wr_en = wen & wr_ok;
  end

  // Read mux sees only current state, so a same-cycle write is not observed.
  always_comb begin
    rd_val = '0;
    if (sel_ctrl)  rd_val = ctrl_q;
    if (sel_stat)  rd_val = status;
    if (sel_istat) rd_val = DATA_W'(irq_stat);
    if (sel_ien)   rd_val = DATA_W'(irq_en);
    if (sel_pend)  rd_val = DATA_W'(pend);
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_per[k]) rd_val = per_sh[k];
      if (sel_dut[k]) rd_val = dut_sh[k];
    end
  end

  // Shadow next-state and reload decision. A reload copies the next-state shadow,
  // so a write coinciding with ch_reload lands straight in the active copy.
  always_comb begin
    force_upd = wr_en & sel_ctrl & wdata[1];
    for (int k = 0; k < NUM_CH; k++) begin
      per_sh_d[k] = (wr_en & sel_per[k]) ? wdata : per_sh[k];
      dut_sh_d[k] = (wr_en & sel_dut[k]) ? wdata : dut_sh[k];
      ch_wr[k]    = wr_en & (sel_per[k] | sel_dut[k]);
      reload[k]   = (ch_reload[k] & (pend[k] | ch_wr[k])) | (force_upd & pend[k]);
    end
  end

  // Event set takes priority over a coincident W1C.
  always_comb begin
    irq_stat_d = irq_stat & ~((wr_en & sel_istat) ? wdata[NUM_CH-1:0] : '0);
    irq_stat_d = irq_stat_d | ch_event;
    irq_en_d   = (wr_en & sel_ien) ? wdata[NUM_CH-1:0] : irq_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      status   <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      bus_err  <= 1'b0;
      irq      <= 1'b0;
      irq_stat <= '0;
      irq_en   <= '0;
      pend     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        per_sh[k]  <= '0;
        dut_sh[k]  <= '0;
        per_act[k] <= '0;
        dut_act[k] <= '0;
      end
    end else begin
      status  <= status_in;
      rvalid  <= ren;
      bus_err <= (ren & ~rd_ok) | (wen & ~wr_ok);
      if (ren) rdata <= rd_ok ? rd_val : '0;
      if (wr_en & sel_ctrl) ctrl_q <= wdata & ~FORCE_MASK;
      irq_stat <= irq_stat_d;
      irq_en   <= irq_en_d;
      irq      <= |(irq_stat_d & irq_en_d);
      for (int k = 0; k < NUM_CH; k++) begin
        per_sh[k] <= per_sh_d[k];
        dut_sh[k] <= dut_sh_d[k];
        if (reload[k]) begin
          per_act[k] <= per_sh_d[k];
          dut_act[k] <= dut_sh_d[k];
          pend[k]    <= 1'b0;
        end else if (ch_wr[k]) begin
          pend[k]    <= 1'b1;
        end
      end
    end
  end

  assign ctrl = ctrl_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign period_o[k*DATA_W +: DATA_W] = per_act[k];
    assign duty_o[k*DATA_W +: DATA_W]   = dut_act[k];
  end

endmodule

// File: tb/tb_pwm_reg_bank.sv
module tb_pwm_reg_bank;
  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic          wen = 1'b0, ren = 1'b0;
  logic [31:0]   rdata, ctrl, status;
  logic          rvalid, bus_err, irq;
  logic [31:0]   status_in = 32'hDEADBEEF;
  logic [N-1:0]  ch_event = '0, ch_reload = '0;
  logic [N*DW-1:0] period_o, duty_o;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_reg_bank #(.NUM_CH(N), .DATA_W(DW), .ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .wen(wen), .ren(ren),
    .rdata(rdata), .rvalid(rvalid), .bus_err(bus_err), .ctrl(ctrl),
    .status_in(status_in), .status(status), .ch_event(ch_event), .ch_reload(ch_reload),
    .period_o(period_o), .duty_o(duty_o), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int K_ILL = 0, K_CTRL = 1, K_STAT = 2, K_ISTAT = 3, K_IEN = 4, K_PEND = 5, K_CH = 6;

  bit [31:0]  m_ctrl, m_status, m_rdata;
  bit         m_rvalid, m_err, m_irq;
  bit [31:0]  m_psh [N];
  bit [31:0]  m_dsh [N];
  bit [31:0]  m_pact[N];
  bit [31:0]  m_dact[N];
  bit [N-1:0] m_pend, m_istat, m_ien;

  // Map a byte address onto a register kind; channel slots are 8 bytes apart.
  function automatic int decode(input int a, output int k, output bit is_duty);
    k = 0; is_duty = 0;
    if (a % 4 != 0) return K_ILL;
    if (a == 0)  return K_CTRL;
    if (a == 4)  return K_STAT;
    if (a == 8)  return K_ISTAT;
    if (a == 12) return K_IEN;
    if (a == 16) return K_PEND;
    if (a >= 32 && a < 32 + 8 * N) begin
      k = (a - 32) / 8;
      is_duty = ((a - 32) % 8) == 4;
      return K_CH;
    end
    return K_ILL;
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_status = 0; m_rdata = 0; m_rvalid = 0; m_err = 0; m_irq = 0;
    m_pend = 0; m_istat = 0; m_ien = 0;
    for (int c = 0; c < N; c++) begin
      m_psh[c] = 0; m_dsh[c] = 0; m_pact[c] = 0; m_dact[c] = 0;
    end
  endtask

  task automatic model_step();
    int kind, k;
    bit dty, writable, forcing;
    bit [N-1:0] written, w1c;
    kind = decode(int'(addr), k, dty);
    writable = (kind != K_ILL) && (kind != K_STAT) && (kind != K_PEND);
    // Read observes the state before this edge.
    m_rvalid = ren;
    if (ren) begin
      case (kind)
        K_CTRL:  m_rdata = m_ctrl;
        K_STAT:  m_rdata = m_status;
        K_ISTAT: m_rdata = 32'(m_istat);
        K_IEN:   m_rdata = 32'(m_ien);
        K_PEND:  m_rdata = 32'(m_pend);
        K_CH:    m_rdata = dty ? m_dsh[k] : m_psh[k];
        default: m_rdata = 0;
      endcase
    end
    m_err = (ren && kind == K_ILL) || (wen && !writable);
    forcing = 0; written = 0; w1c = 0;
    if (wen && writable) begin
      case (kind)
        K_CTRL:  begin m_ctrl = wdata & ~32'h2; forcing = wdata[1]; end
        K_ISTAT: w1c = wdata[N-1:0];
        K_IEN:   m_ien = wdata[N-1:0];
        K_CH:    begin
                   if (dty) m_dsh[k] = wdata; else m_psh[k] = wdata;
                   written[k] = 1;
                 end
        default: ;
      endcase
    end
    for (int c = 0; c < N; c++) begin
      if ((ch_reload[c] && (m_pend[c] || written[c])) || (forcing && m_pend[c])) begin
        m_pact[c] = m_psh[c];
        m_dact[c] = m_dsh[c];
        m_pend[c] = 0;
      end else if (written[c]) begin
        m_pend[c] = 1;
      end
    end
    m_istat  = (m_istat & ~w1c) | ch_event;
    m_irq    = |(m_istat & m_ien);
    m_status = status_in;
  endtask

  always @(posedge clk) begin
    logic [N*DW-1:0] ep, ed;
    if (!reset_n) model_reset();
    else model_step();
    #1;
    for (int c = 0; c < N; c++) begin
      ep[c*DW +: DW] = m_pact[c];
      ed[c*DW +: DW] = m_dact[c];
    end
    check("rdata",    rdata,    m_rdata);
    check("rvalid",   rvalid,   m_rvalid);
    check("bus_err",  bus_err,  m_err);
    check("ctrl",     ctrl,     m_ctrl);
    check("status",   status,   m_status);
    check("irq",      irq,      m_irq);
    check("period_o", period_o, ep);
    check("duty_o",   duty_o,   ed);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic w, input logic r, input logic [7:0] a, input logic [31:0] d,
                       input logic [N-1:0] ev, input logic [N-1:0] rl);
    @(negedge clk);
    wen = w; ren = r; addr = a; wdata = d; ch_event = ev; ch_reload = rl;
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 32'h0, '0, '0);
  endtask

  // Read then idle; the result is checked at the following negedge.
  task automatic read_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    drive(0, 1, a, 32'h0, '0, '0);
    idle();
    check({name, "_rd"}, rdata, exp);
    check({name, "_rv"}, rvalid, 1'b1);
  endtask

  initial begin
    logic [7:0] ra;
    #1;
    check("rst_rdata",  rdata, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_irq",    irq, 0);
    check("rst_status", status, 0);
    check("rst_period", period_o, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // CTRL / STATUS
    drive(1, 0, 8'h00, 32'h12345678, '0, '0);
    read_chk("ctrl", 8'h00, 32'h12345678);
    check("ctrl_out", ctrl, 32'h12345678);
    read_chk("status", 8'h04, 32'hDEADBEEF);

    // Shadow / active on channel 2
    drive(1, 0, 8'h30, 32'd1000, '0, '0);
    drive(1, 0, 8'h34, 32'd250, '0, '0);
    read_chk("pend_ch2", 8'h10, 32'h4);
    check("ch2_per_before", period_o[2*DW +: DW], 0);
    read_chk("per2_shadow", 8'h30, 32'd1000);
    drive(0, 0, 8'h00, 32'h0, '0, 4'b0100);
    idle();
    check("ch2_per_after", period_o[2*DW +: DW], 1000);
    check("ch2_duty_after", duty_o[2*DW +: DW], 250);
    read_chk("pend_clr", 8'h10, 32'h0);

    // Force update
    drive(1, 0, 8'h20, 32'd10, '0, '0);
    drive(1, 0, 8'h38, 32'd40, '0, '0);
    drive(1, 0, 8'h00, 32'h2, '0, '0);
    idle();
    check("force_ch0", period_o[0 +: DW], 10);
    check("force_ch3", period_o[3*DW +: DW], 40);
    read_chk("force_pend", 8'h10, 32'h0);
    read_chk("force_ctrl", 8'h00, 32'h0);

    // Interrupts
    drive(1, 0, 8'h0C, 32'h1, '0, '0);
    drive(0, 0, 8'h00, 32'h0, 4'b0010, '0);
    idle();
    check("irq_masked", irq, 0);
    read_chk("istat_2", 8'h08, 32'h2);
    drive(0, 0, 8'h00, 32'h0, 4'b0001, '0);
    idle();
    check("irq_set", irq, 1);
    drive(1, 0, 8'h08, 32'h1, 4'b0001, '0);
    read_chk("istat_setwins", 8'h08, 32'h3);
    drive(1, 0, 8'h08, 32'h3, '0, '0);
    idle();
    check("irq_clr", irq, 0);
    read_chk("istat_0", 8'h08, 32'h0);

    // Errors
    drive(0, 1, 8'h02, 32'h0, '0, '0);
    idle();
    check("err_unaligned", bus_err, 1);
    check("err_unaligned_rd", rdata, 0);
    drive(0, 1, 8'h1C, 32'h0, '0, '0);
    idle();
    check("err_unmapped", bus_err, 1);
    drive(1, 0, 8'h04, 32'hFFFFFFFF, '0, '0);
    idle();
    check("err_wr_status", bus_err, 1);
    read_chk("status_kept", 8'h04, 32'hDEADBEEF);

    // Write coinciding with reload on channel 1
    drive(1, 0, 8'h2C, 32'd77, '0, 4'b0010);
    idle();
    check("fwd_duty1", duty_o[1*DW +: DW], 77);
    read_chk("fwd_pend", 8'h10, 32'h0);

    // Randomised traffic checked by the model every cycle
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 8'(4 * $urandom_range(0, 4));
        1: ra = 8'(32 + 4 * $urandom_range(0, 2 * N - 1));
        2: ra = 8'($urandom_range(0, 255));
        default: ra = 8'(4 * $urandom_range(0, 15));
      endcase
      status_in = $urandom;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom,
            ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
            ($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
    end
    idle();

    // Asynchronous reset in the middle of a read
    drive(1, 0, 8'h00, 32'hA5A5A5A5, '0, '0);
    drive(0, 1, 8'h00, 32'h0, '0, '0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ctrl",   ctrl, 0);
    check("arst_rvalid", rvalid, 0);
    check("arst_rdata",  rdata, 0);
    check("arst_duty",   duty_o, 0);
    @(posedge clk);
    #2;
    check("arst_no_rvalid", rvalid, 0);
    @(negedge clk);
    ren = 1'b0;
    reset_n = 1'b1;
    repeat (3) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
